// File: rtl/nq_decode_stage.sv
// nq_decode_stage: instruction decode stage for a 16-bit NQ core.
// Holds the 8 x 16 register file with write-through bypass. It decodes
// instr_in combinationally and captures the decode into a single pipeline
// register that can be flushed (bubble) or stalled (hold).
module nq_decode_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr_in,
    input  logic        instr_valid,
    input  logic [31:0] PC_in,
    input  logic        stall,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [2:0]  wb_addr,
    input  logic [15:0] wb_data,
    output logic [15:0] reg1data_out,
    output logic [15:0] reg2data_out,
    output logic [7:0]  imm_out,
    output logic [5:0]  memaddr_out,
    output logic [4:0]  boffset_out,
    output logic [2:0]  funct_out,
    output logic [1:0]  op_out,
    output logic [1:0]  shamt_out,
    output logic [2:0]  dest_out,
    output logic        bne_out,
    output logic        jr_out,
    output logic        jmp_out,
    output logic        memread_out,
    output logic        memwrite_out,
    output logic        regwrite_out,
    output logic [31:0] PC_out,
    output logic        valid_out
);

    // Major opcodes, instr[15:14]
    localparam logic [1:0] OP_R = 2'b00;
    localparam logic [1:0] OP_I = 2'b01;
    localparam logic [1:0] OP_J = 2'b10;
    localparam logic [1:0] OP_B = 2'b11;

    // I-type function codes
    localparam logic [2:0] I_LUI = 3'b000;
    localparam logic [2:0] I_LBI = 3'b001;
    localparam logic [2:0] I_LW  = 3'b100;
    localparam logic [2:0] I_LB  = 3'b101;
    localparam logic [2:0] I_SW  = 3'b110;
    localparam logic [2:0] I_SB  = 3'b111;

    // J-type function codes
    localparam logic [2:0] J_JMP = 3'b000;
    localparam logic [2:0] J_JR  = 3'b001;

    // Branch function code that requests a not-equal compare
    localparam logic [2:0] B_BNE = 3'b000;

    // Everything the stage presents to execute, captured as one word so
    // that flush and reset can clear it in a single assignment.
    typedef struct packed {
        logic [15:0] reg1;
        logic [15:0] reg2;
        logic [7:0]  imm;
        logic [5:0]  memaddr;
        logic [4:0]  boffset;
        logic [2:0]  funct;
        logic [1:0]  op;
        logic [1:0]  shamt;
        logic [2:0]  dest;
        logic        bne;
        logic        jr;
        logic        jmp;
        logic        memread;
        logic        memwrite;
        logic        regwrite;
        logic [31:0] pc;
        logic        valid;
    } stage_t;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    // Each word is its own register because reset must clear all eight
    // at once; the flat array only exists for indexed reads.
    logic [15:0] rf_word [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi = gi + 1) begin : g_rf
            logic [15:0] word_reg;

            // Writeback port: writes whenever enabled, independent of stall/flush
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    word_reg <= '0;
                end else if (wb_en && (wb_addr == 3'(gi))) begin
                    word_reg <= wb_data;
                end
            end

            assign rf_word[gi] = word_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Field decode
    // ------------------------------------------------------------------
    logic [1:0]  op_dec;
    logic [2:0]  funct_dec;
    logic [2:0]  dest_dec;
    logic [2:0]  src1_idx;
    logic [2:0]  src2_idx;
    logic [1:0]  shamt_dec;
    logic        jr_dec;
    logic        jmp_dec;
    logic        memread_dec;
    logic        memwrite_dec;
    logic        regwrite_dec;
    logic        is_branch;

    assign op_dec = instr_in[15:14];

    // Split the instruction into register indices, function code and
    // static control flags; unused source indices fall back to r0.
    always_comb begin
        funct_dec    = 3'b000;
        dest_dec     = 3'b000;
        src1_idx     = 3'b000;
        src2_idx     = 3'b000;
        shamt_dec    = 2'b00;
        jr_dec       = 1'b0;
        jmp_dec      = 1'b0;
        memread_dec  = 1'b0;
        memwrite_dec = 1'b0;
        regwrite_dec = 1'b0;
        is_branch    = 1'b0;

        case (op_dec)
            OP_R: begin
                dest_dec     = instr_in[13:11];
                src1_idx     = instr_in[10:8];
                src2_idx     = instr_in[7:5];
                funct_dec    = instr_in[2:0];
                shamt_dec    = instr_in[4:3];
                regwrite_dec = 1'b1;
            end
            OP_I: begin
                funct_dec = instr_in[13:11];
                dest_dec  = instr_in[10:8];
                src1_idx  = instr_in[10:8];
                shamt_dec = instr_in[1:0];
                case (instr_in[13:11])
                    I_LUI, I_LBI: regwrite_dec = 1'b1;
                    I_LW, I_LB: begin
                        regwrite_dec = 1'b1;
                        memread_dec  = 1'b1;
                    end
                    I_SW, I_SB: memwrite_dec = 1'b1;
                    default: ;
                endcase
            end
            OP_J: begin
                funct_dec = instr_in[13:11];
                src1_idx  = instr_in[10:8];
                case (instr_in[13:11])
                    J_JMP: jmp_dec = 1'b1;
                    J_JR: begin
                        jmp_dec = 1'b1;
                        jr_dec  = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_B: begin
                src1_idx  = instr_in[13:11];
                src2_idx  = instr_in[10:8];
                funct_dec = instr_in[2:0];
                is_branch = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand read with write-through bypass
    // ------------------------------------------------------------------
    // A write landing on this same edge must be seen by the instruction
    // being captured, so the writeback data overrides the stored word.
    logic [15:0] rd1_data;
    logic [15:0] rd2_data;

    assign rd1_data = (wb_en && (wb_addr == src1_idx)) ? wb_data : rf_word[src1_idx];
    assign rd2_data = (wb_en && (wb_addr == src2_idx)) ? wb_data : rf_word[src2_idx];

    // ------------------------------------------------------------------
    // Pipeline register
    // ------------------------------------------------------------------
    stage_t pipe_reg;
    stage_t pipe_next;
    stage_t load_word;

    // Assemble the word a load would capture; flags only for valid slots
    always_comb begin
        load_word          = '0;
        load_word.reg1     = rd1_data;
        load_word.reg2     = rd2_data;
        load_word.imm      = instr_in[7:0];
        load_word.memaddr  = instr_in[7:2];
        load_word.boffset  = instr_in[7:3];
        load_word.funct    = funct_dec;
        load_word.op       = op_dec;
        load_word.shamt    = shamt_dec;
        load_word.dest     = dest_dec;
        load_word.pc       = PC_in;
        load_word.valid    = instr_valid;
        // bne resolves here on the full 16-bit bypassed operands
        load_word.bne      = instr_valid && is_branch && (funct_dec == B_BNE)
                             && (rd1_data != rd2_data);
        load_word.jr       = instr_valid && jr_dec;
        load_word.jmp      = instr_valid && jmp_dec;
        load_word.memread  = instr_valid && memread_dec;
        load_word.memwrite = instr_valid && memwrite_dec;
        load_word.regwrite = instr_valid && regwrite_dec;
    end

    // Edge priority: flush inserts a zero bubble, else stall holds, else load
    always_comb begin
        pipe_next = load_word;
        if (flush) begin
            pipe_next = '0;
        end else if (stall) begin
            pipe_next = pipe_reg;
        end
    end

    // Stage register; reset clears it immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_reg <= '0;
        end else begin
            pipe_reg <= pipe_next;
        end
    end

    assign reg1data_out = pipe_reg.reg1;
    assign reg2data_out = pipe_reg.reg2;
    assign imm_out      = pipe_reg.imm;
    assign memaddr_out  = pipe_reg.memaddr;
    assign boffset_out  = pipe_reg.boffset;
    assign funct_out    = pipe_reg.funct;
    assign op_out       = pipe_reg.op;
    assign shamt_out    = pipe_reg.shamt;
    assign dest_out     = pipe_reg.dest;
    assign bne_out      = pipe_reg.bne;
    assign jr_out       = pipe_reg.jr;
    assign jmp_out      = pipe_reg.jmp;
    assign memread_out  = pipe_reg.memread;
    assign memwrite_out = pipe_reg.memwrite;
    assign regwrite_out = pipe_reg.regwrite;
    assign PC_out       = pipe_reg.pc;
    assign valid_out    = pipe_reg.valid;

endmodule

// File: tb/tb_nq_decode_stage.sv
// tb_nq_decode_stage: table-driven directed bench for nq_decode_stage.
// Each table row is applied for one clock and the registered outputs are
// compared one time unit after the edge; asynchronous reset is exercised
// by hand-written sequences before and after the table.
module tb_nq_decode_stage;

    logic        clk;
    logic        rst;
    logic [15:0] instr_in;
    logic        instr_valid;
    logic [31:0] PC_in;
    logic        stall;
    logic        flush;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic [15:0] reg1data_out;
    logic [15:0] reg2data_out;
    logic [7:0]  imm_out;
    logic [5:0]  memaddr_out;
    logic [4:0]  boffset_out;
    logic [2:0]  funct_out;
    logic [1:0]  op_out;
    logic [1:0]  shamt_out;
    logic [2:0]  dest_out;
    logic        bne_out;
    logic        jr_out;
    logic        jmp_out;
    logic        memread_out;
    logic        memwrite_out;
    logic        regwrite_out;
    logic [31:0] PC_out;
    logic        valid_out;

    int n_cmp = 0;
    int n_bad = 0;

    nq_decode_stage dut (
        .clk          (clk),
        .rst          (rst),
        .instr_in     (instr_in),
        .instr_valid  (instr_valid),
        .PC_in        (PC_in),
        .stall        (stall),
        .flush        (flush),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .reg1data_out (reg1data_out),
        .reg2data_out (reg2data_out),
        .imm_out      (imm_out),
        .memaddr_out  (memaddr_out),
        .boffset_out  (boffset_out),
        .funct_out    (funct_out),
        .op_out       (op_out),
        .shamt_out    (shamt_out),
        .dest_out     (dest_out),
        .bne_out      (bne_out),
        .jr_out       (jr_out),
        .jmp_out      (jmp_out),
        .memread_out  (memread_out),
        .memwrite_out (memwrite_out),
        .regwrite_out (regwrite_out),
        .PC_out       (PC_out),
        .valid_out    (valid_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One row: stimulus for one clock plus the outputs expected after it.
    // flags = {bne, jr, jmp, memread, memwrite, regwrite}
    typedef struct {
        logic        st;
        logic        fl;
        logic        we;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic [15:0] ins;
        logic        iv;
        logic [31:0] pc;
        logic [15:0] e_r1;
        logic [15:0] e_r2;
        logic [7:0]  e_imm;
        logic [2:0]  e_dest;
        logic [2:0]  e_funct;
        logic [1:0]  e_op;
        logic [1:0]  e_sh;
        logic [5:0]  e_flags;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];
    vec_t zero_v;

    function automatic vec_t mk(
        input logic st, input logic fl, input logic we, input logic [2:0] wa,
        input logic [15:0] wd, input logic [15:0] ins, input logic iv,
        input logic [31:0] pc, input logic [15:0] r1, input logic [15:0] r2,
        input logic [7:0] imm, input logic [2:0] dest, input logic [2:0] funct,
        input logic [1:0] op, input logic [1:0] sh, input logic [5:0] flags,
        input logic ev, input logic [31:0] epc);
        vec_t v;
        v.st = st;  v.fl = fl;  v.we = we;  v.wa = wa;  v.wd = wd;
        v.ins = ins;  v.iv = iv;  v.pc = pc;
        v.e_r1 = r1;  v.e_r2 = r2;  v.e_imm = imm;  v.e_dest = dest;
        v.e_funct = funct;  v.e_op = op;  v.e_sh = sh;  v.e_flags = flags;
        v.e_valid = ev;  v.e_pc = epc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare every output port against one expectation record
    task automatic check_outputs(input vec_t v, input string tag);
        logic [7:0] e_imm;
        e_imm = v.e_imm;
        check({tag, " reg1data"}, 32'(reg1data_out), 32'(v.e_r1));
        check({tag, " reg2data"}, 32'(reg2data_out), 32'(v.e_r2));
        check({tag, " imm"},      32'(imm_out),      32'(e_imm));
        check({tag, " memaddr"},  32'(memaddr_out),  32'(e_imm[7:2]));
        check({tag, " boffset"},  32'(boffset_out),  32'(e_imm[7:3]));
        check({tag, " dest"},     32'(dest_out),     32'(v.e_dest));
        check({tag, " funct"},    32'(funct_out),    32'(v.e_funct));
        check({tag, " op"},       32'(op_out),       32'(v.e_op));
        check({tag, " shamt"},    32'(shamt_out),    32'(v.e_sh));
        check({tag, " flags"},
              32'({bne_out, jr_out, jmp_out, memread_out, memwrite_out, regwrite_out}),
              32'(v.e_flags));
        check({tag, " valid"},    32'(valid_out),    32'(v.e_valid));
        check({tag, " pc"},       PC_out,            v.e_pc);
    endtask

    initial begin
        int bad_before;
        logic [2:0] ri;

        zero_v = mk(0,0,0,3'd0,16'h0, 16'h0,0,32'h0,
                    16'h0,16'h0,8'h00,3'd0,3'd0,2'd0,2'd0,6'b000000,0,32'h0);

        //            st fl we wa     wd         ins       iv pc
        //            r1         r2        imm    dest  funct op    sh    flags      v  pc
        vecs[0]  = mk(0,0,1,3'd2,16'h0005, 16'h0000,0,32'h000,
                      16'h0000,16'h0000,8'h00,3'd0,3'd0,2'd0,2'd0,6'b000000,0,32'h000);
        vecs[1]  = mk(0,0,1,3'd3,16'h0003, 16'h0000,0,32'h000,
                      16'h0000,16'h0000,8'h00,3'd0,3'd0,2'd0,2'd0,6'b000000,0,32'h000);
        // R add-style: rd1, rs2, rt3, funct 101
        vecs[2]  = mk(0,0,0,3'd0,16'h0000, 16'h0A65,1,32'h100,
                      16'h0005,16'h0003,8'h65,3'd1,3'd5,2'd0,2'd0,6'b000001,1,32'h100);
        // write r4 on the same edge the instruction reading r4 is loaded
        vecs[3]  = mk(0,0,1,3'd4,16'hBEEF, 16'h2C5B,1,32'h104,
                      16'hBEEF,16'h0005,8'h5B,3'd5,3'd3,2'd0,2'd3,6'b000001,1,32'h104);
        vecs[4]  = mk(0,0,1,3'd1,16'h7FFF, 16'h0000,0,32'h108,
                      16'h0000,16'h0000,8'h00,3'd0,3'd0,2'd0,2'd0,6'b000000,0,32'h108);
        // BNE r1 vs r2 (r2 bypassed): not equal, then equal
        vecs[5]  = mk(0,0,1,3'd2,16'h7FFE, 16'hCAA8,1,32'h10C,
                      16'h7FFF,16'h7FFE,8'hA8,3'd0,3'd0,2'd3,2'd0,6'b100000,1,32'h10C);
        vecs[6]  = mk(0,0,1,3'd2,16'h7FFF, 16'hCAA8,1,32'h110,
                      16'h7FFF,16'h7FFF,8'hA8,3'd0,3'd0,2'd3,2'd0,6'b000000,1,32'h110);
        // LW r6, memaddr 010101
        vecs[7]  = mk(0,0,1,3'd6,16'h1234, 16'h6656,1,32'h114,
                      16'h1234,16'h0000,8'h56,3'd6,3'd4,2'd1,2'd2,6'b000101,1,32'h114);
        // SB r3
        vecs[8]  = mk(0,0,0,3'd0,16'h0000, 16'h7B0F,1,32'h118,
                      16'h0003,16'h0000,8'h0F,3'd3,3'd7,2'd1,2'd3,6'b000010,1,32'h118);
        // JR r4
        vecs[9]  = mk(0,0,0,3'd0,16'h0000, 16'h8C3C,1,32'h11C,
                      16'hBEEF,16'h0000,8'h3C,3'd0,3'd1,2'd2,2'd0,6'b011000,1,32'h11C);
        // J-type funct 010: no flags
        vecs[10] = mk(0,0,0,3'd0,16'h0000, 16'h9100,1,32'h120,
                      16'h7FFF,16'h0000,8'h00,3'd0,3'd2,2'd2,2'd0,6'b000000,1,32'h120);
        // flush with a write to r7 in the same cycle
        vecs[11] = mk(0,1,1,3'd7,16'h00AA, 16'h0A65,1,32'h124,
                      16'h0000,16'h0000,8'h00,3'd0,3'd0,2'd0,2'd0,6'b000000,0,32'h000);
        vecs[12] = mk(0,0,0,3'd0,16'h0000, 16'h0700,1,32'h128,
                      16'h00AA,16'h0000,8'h00,3'd0,3'd0,2'd0,2'd0,6'b000001,1,32'h128);
        // JMP reading r3
        vecs[13] = mk(0,0,0,3'd0,16'h0000, 16'h83FF,1,32'h12C,
                      16'h0003,16'h0000,8'hFF,3'd0,3'd0,2'd2,2'd0,6'b001000,1,32'h12C);
        // three stalled cycles with new instructions: outputs hold row 13
        vecs[14] = mk(1,0,1,3'd3,16'h9999, 16'h0A65,1,32'h200,
                      16'h0003,16'h0000,8'hFF,3'd0,3'd0,2'd2,2'd0,6'b001000,1,32'h12C);
        vecs[15] = mk(1,0,0,3'd0,16'h0000, 16'h6656,1,32'h204,
                      16'h0003,16'h0000,8'hFF,3'd0,3'd0,2'd2,2'd0,6'b001000,1,32'h12C);
        vecs[16] = mk(1,0,0,3'd0,16'h0000, 16'hCAA8,1,32'h208,
                      16'h0003,16'h0000,8'hFF,3'd0,3'd0,2'd2,2'd0,6'b001000,1,32'h12C);
        // stall and flush together: flush wins
        vecs[17] = mk(1,1,0,3'd0,16'h0000, 16'h0A65,1,32'h20C,
                      16'h0000,16'h0000,8'h00,3'd0,3'd0,2'd0,2'd0,6'b000000,0,32'h000);
        // r3 was written during the stall
        vecs[18] = mk(0,0,0,3'd0,16'h0000, 16'h83FF,1,32'h130,
                      16'h9999,16'h0000,8'hFF,3'd0,3'd0,2'd2,2'd0,6'b001000,1,32'h130);
        // LUI r5
        vecs[19] = mk(0,0,0,3'd0,16'h0000, 16'h4580,1,32'h134,
                      16'h0000,16'h0000,8'h80,3'd5,3'd0,2'd1,2'd0,6'b000001,1,32'h134);
        // branch funct 001 with unequal operands: no bne
        vecs[20] = mk(0,0,0,3'd0,16'h0000, 16'hC801,1,32'h138,
                      16'h7FFF,16'h0000,8'h01,3'd0,3'd1,2'd3,2'd0,6'b000000,1,32'h138);
        // LW with instr_valid=0: flags cleared, data captured as-is
        vecs[21] = mk(0,0,0,3'd0,16'h0000, 16'h6656,0,32'h13C,
                      16'h1234,16'h0000,8'h56,3'd6,3'd4,2'd1,2'd2,6'b000000,0,32'h13C);

        rst = 1'b1;  instr_in = '0;  instr_valid = 1'b0;  PC_in = '0;
        stall = 1'b0;  flush = 1'b0;  wb_en = 1'b0;  wb_addr = '0;  wb_data = '0;

        #2;
        check_outputs(zero_v, "reset");
        $display("reset: outputs checked, errors so far %0d", n_bad);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            bad_before  = n_bad;
            stall       = vecs[i].st;
            flush       = vecs[i].fl;
            wb_en       = vecs[i].we;
            wb_addr     = vecs[i].wa;
            wb_data     = vecs[i].wd;
            instr_in    = vecs[i].ins;
            instr_valid = vecs[i].iv;
            PC_in       = vecs[i].pc;
            @(posedge clk);
            #1;
            check_outputs(vecs[i], $sformatf("vec%0d", i));
            $display("vec %0d: instr=%h stall=%b flush=%b wb=%b r%0d=%h -> r1=%h r2=%h valid=%b errors=%0d",
                     i, vecs[i].ins, vecs[i].st, vecs[i].fl, vecs[i].we, vecs[i].wa,
                     vecs[i].wd, reg1data_out, reg2data_out, valid_out, n_bad - bad_before);
        end

        // Asynchronous reset between edges, with a write request pending
        stall = 1'b0;  flush = 1'b0;
        #3;
        wb_en = 1'b1;  wb_addr = 3'd1;  wb_data = 16'h5555;
        rst = 1'b1;
        #1;
        check_outputs(zero_v, "midrst");
        $display("midrst: outputs checked immediately, errors so far %0d", n_bad);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wb_en = 1'b0;

        // Every register must read back as zero after reset
        for (int i = 0; i < 8; i++) begin
            ri          = 3'(i);
            instr_in    = {2'b00, 3'b000, ri, ri, 5'b00000};
            instr_valid = 1'b1;
            PC_in       = 32'h300 + 32'(i * 4);
            @(posedge clk);
            #1;
            check($sformatf("postrst r%0d src1", i), 32'(reg1data_out), 32'h0);
            check($sformatf("postrst r%0d src2", i), 32'(reg2data_out), 32'h0);
            check($sformatf("postrst r%0d valid", i), 32'(valid_out), 32'h1);
            $display("postrst read r%0d: r1=%h r2=%h", i, reg1data_out, reg2data_out);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
